// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB geometry, controller state encoding and strobe constants.
// Imported by the BTB update controller, its FIFO and the IF-side lookup logic.
package btb_update_ctrl_pkg;

   localparam int IDX_W   = 6;
   localparam int TAG_W   = 10;
   localparam int TGT_W   = 18;
   localparam int Q_DEPTH = 4;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } upd_state_t;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Control/data bundle between EX, the BTB write port, IF and the update controller.
// The master side is the update controller itself.
interface btb_update_ctrl_if
   import btb_update_ctrl_pkg::*;
#(
   parameter int IDX_W = btb_update_ctrl_pkg::IDX_W,
   parameter int TAG_W = btb_update_ctrl_pkg::TAG_W,
   parameter int TGT_W = btb_update_ctrl_pkg::TGT_W
);
   logic             rdy;
   logic             ex_valid;
   logic [31:0]      ex_pc;
   logic             ex_taken;
   logic [31:0]      ex_target;
   logic             ex_ready;
   logic             flush_all;
   logic             btb_we;
   logic             btb_clr;
   logic [IDX_W-1:0] btb_idx;
   logic [TAG_W-1:0] btb_tag;
   logic [TGT_W-1:0] btb_tgt;
   logic             btb_taken;
   logic             lookup_en;
   logic             init_done;

   modport master (
      input  rdy, ex_valid, ex_pc, ex_taken, ex_target, flush_all,
      output ex_ready, btb_we, btb_clr, btb_idx, btb_tag, btb_tgt, btb_taken,
             lookup_en, init_done
   );

   modport slave (
      output rdy, ex_valid, ex_pc, ex_taken, ex_target, flush_all,
      input  ex_ready, btb_we, btb_clr, btb_idx, btb_tag, btb_tgt, btb_taken,
             lookup_en, init_done
   );

endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO for pending BTB updates; i_clr empties it and wins over push/pop.
// Callers must not push when full nor pop when empty.
module btb_upd_fifo
   import btb_update_ctrl_pkg::*;
#(
   parameter int DEPTH  = Q_DEPTH,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [DATA_W-1:0] o_head
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences all BTB writes: clear sweeps after reset/flush, then drains queued EX updates.
// lookup_en is only asserted while the BTB contents are known-clean (RUN).
module btb_update_ctrl
   import btb_update_ctrl_pkg::*;
#(
   parameter int IDX_W   = btb_update_ctrl_pkg::IDX_W,
   parameter int TAG_W   = btb_update_ctrl_pkg::TAG_W,
   parameter int TGT_W   = btb_update_ctrl_pkg::TGT_W,
   parameter int Q_DEPTH = btb_update_ctrl_pkg::Q_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   btb_update_ctrl_if.master bus
);
   localparam int ENT_W = IDX_W + TAG_W + TGT_W + 1;

   upd_state_t       r_state;
   logic [IDX_W-1:0] r_sweep_idx;
   logic             r_we;
   logic             r_clr;
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   logic [TGT_W-1:0] r_tgt;
   logic             r_taken;
   logic             r_init_done;

   logic             w_run;
   logic             w_flush;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [ENT_W-1:0] w_push_data;
   logic [ENT_W-1:0] w_head;
   logic             w_unused;

   assign w_run   = (r_state == ST_RUN);
   // A flush edge drops both the same-cycle push and any pending pop.
   assign w_flush = bus.rdy && bus.flush_all && w_run;
   assign w_push  = bus.rdy && bus.ex_valid && !w_full && !w_flush;
   assign w_pop   = bus.rdy && w_run && !bus.flush_all && !w_empty;

   assign w_push_data = {bus.ex_pc[IDX_W+1:2],
                         bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2],
                         bus.ex_target[TGT_W-1:0],
                         bus.ex_taken};
   assign w_unused = ^{bus.ex_pc[31:IDX_W+TAG_W+2], bus.ex_pc[1:0],
                       bus.ex_target[31:TGT_W]};

   btb_upd_fifo #(
      .DEPTH  (Q_DEPTH),
      .DATA_W (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_sweep_idx <= '0;
         r_we        <= DISABLE;
         r_clr       <= DISABLE;
         r_idx       <= '0;
         r_tag       <= '0;
         r_tgt       <= '0;
         r_taken     <= DISABLE;
         r_init_done <= DISABLE;
      end else begin
         r_we  <= DISABLE;
         r_clr <= DISABLE;
         if (bus.rdy) begin
            case (r_state)
               ST_INIT, ST_FLUSH: begin
                  r_we        <= ENABLE;
                  r_clr       <= ENABLE;
                  r_idx       <= r_sweep_idx;
                  r_sweep_idx <= r_sweep_idx + 1'b1;
                  if (r_sweep_idx == '1) begin
                     r_state <= ST_RUN;
                     if (r_state == ST_INIT) r_init_done <= ENABLE;
                  end
               end
               ST_RUN: begin
                  if (bus.flush_all) begin
                     r_state     <= ST_FLUSH;
                     r_sweep_idx <= '0;
                  end else if (!w_empty) begin
                     r_we    <= ENABLE;
                     r_idx   <= w_head[ENT_W-1 -: IDX_W];
                     r_tag   <= w_head[TAG_W+TGT_W -: TAG_W];
                     r_tgt   <= w_head[TGT_W:1];
                     r_taken <= w_head[0];
                  end
               end
               default: r_state <= ST_INIT;
            endcase
         end
      end
   end

   assign bus.ex_ready  = !w_full;
   assign bus.lookup_en = w_run;
   assign bus.btb_we    = r_we;
   assign bus.btb_clr   = r_clr;
   assign bus.btb_idx   = r_idx;
   assign bus.btb_tag   = r_tag;
   assign bus.btb_tgt   = r_tgt;
   assign bus.btb_taken = r_taken;
   assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed sweep/drain/flush scenarios plus random traffic,
// all checked cycle by cycle against a queue-based model of the update rules.
module tb_btb_update_ctrl;
   import btb_update_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   btb_update_ctrl_if bus_if ();

   btb_update_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: pending updates as raw EX records, sweep as a plain counter.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
   } upd_t;

   upd_t m_q[$];
   bit   m_sweep;
   bit   m_first;
   bit   m_init;
   int   m_sw;
   bit   e_we, e_clr, e_taken;
   int   e_idx, e_tag, e_tgt;

   int unsigned n_clr_wr  = 0;
   int unsigned n_data_wr = 0;

   task automatic drive(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg, input bit fl);
      bus_if.rdy       = r;
      bus_if.ex_valid  = v;
      bus_if.ex_pc     = pc;
      bus_if.ex_taken  = tk;
      bus_if.ex_target = tg;
      bus_if.flush_all = fl;
   endtask

   task automatic check_outputs();
      chk("btb_we",    32'(bus_if.btb_we),    32'(e_we));
      chk("btb_clr",   32'(bus_if.btb_clr),   32'(e_clr));
      chk("btb_idx",   32'(bus_if.btb_idx),   32'(e_idx));
      if (e_we && !e_clr) begin
         chk("btb_tag",   32'(bus_if.btb_tag),   32'(e_tag));
         chk("btb_tgt",   32'(bus_if.btb_tgt),   32'(e_tgt));
         chk("btb_taken", 32'(bus_if.btb_taken), 32'(e_taken));
      end
      chk("lookup_en", 32'(bus_if.lookup_en), 32'(!m_sweep));
      chk("init_done", 32'(bus_if.init_done), 32'(m_init));
      if (bus_if.btb_we &&  bus_if.btb_clr) n_clr_wr++;
      if (bus_if.btb_we && !bus_if.btb_clr) n_data_wr++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      m_q.delete();
      m_sweep = 1; m_first = 1; m_init = 0; m_sw = 0;
      e_we = 0; e_clr = 0; e_taken = 0; e_idx = 0; e_tag = 0; e_tgt = 0;
      #1;
      check_outputs();
      chk("rst_tag", 32'(bus_if.btb_tag), 32'h0);
      chk("rst_tgt", 32'(bus_if.btb_tgt), 32'h0);
      rst = 1'b0;
   endtask

   task automatic step(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit fl);
      bit   accept;
      bit   drop;
      upd_t u;
      drive(r, v, pc, tk, tg, fl);
      accept = (m_q.size() < 4);
      chk("ex_ready", 32'(bus_if.ex_ready), 32'(accept));
      @(posedge clk);
      e_we = 0; e_clr = 0; drop = 0;
      if (r) begin
         if (m_sweep) begin
            e_we = 1; e_clr = 1; e_idx = m_sw;
            m_sw++;
            if (m_sw == 64) begin
               m_sweep = 0;
               if (m_first) m_init = 1;
               m_first = 0;
            end
         end else if (fl) begin
            m_q.delete();
            m_sweep = 1; m_sw = 0; drop = 1;
         end else if (m_q.size() > 0) begin
            u = m_q.pop_front();
            e_we    = 1;
            e_idx   = int'((u.pc >> 2) % 64);
            e_tag   = int'((u.pc >> 8) % 1024);
            e_tgt   = int'(u.tgt % (1 << 18));
            e_taken = u.taken;
         end
         if (v && accept && !drop) m_q.push_back('{pc, tg, tk});
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input bit r);
      step(r, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic finish_sweep();
      int guard = 0;
      while (m_sweep && guard < 200) begin
         idle(1'b1);
         guard++;
      end
      chk("sweep_bound", 32'(guard < 200), 32'h1);
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      do_reset();

      // Initial sweep with a push at idx 10, then a 5-cycle rdy stall at idx 20.
      for (int i = 0; i < 20; i++) begin
         if (i == 10) step(1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_5678, 1'b0);
         else         idle(1'b1);
      end
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1, 1'b0);
      idle(1'b1);
      chk("resume_idx", 32'(bus_if.btb_idx), 32'd20);
      finish_sweep();
      chk("init_done_end", 32'(bus_if.init_done), 32'h1);
      idle(1'b1);
      chk("sweep_push_idx", 32'(bus_if.btb_idx), 32'h0D);
      chk("sweep_push_tag", 32'(bus_if.btb_tag), 32'h12);
      idle(1'b1);

      // Single push in RUN: write appears after the next edge.
      step(1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0200, 1'b0);
      idle(1'b1);
      chk("single_we",  32'(bus_if.btb_we),  32'h1);
      chk("single_idx", 32'(bus_if.btb_idx), 32'h1);
      chk("single_tgt", 32'(bus_if.btb_tgt), 32'h200);
      idle(1'b1);
      chk("single_we_drop", 32'(bus_if.btb_we), 32'h0);

      // Queue 3 entries during a flush sweep, then flush again before any drain.
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 32'h0000_1000 + 32'(i * 4), 1'b1, 32'h0000_0400, 1'b0);
      finish_sweep();
      n_clr_wr = 0; n_data_wr = 0;
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      finish_sweep();
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("flush_clr_writes",  32'(n_clr_wr),  32'd64);
      chk("flush_data_writes", 32'(n_data_wr), 32'd0);

      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 8, 1'($urandom), $urandom, 1'($urandom),
                 $urandom, $urandom_range(0, 99) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
